cpu_bus_io: RTL and testbench

Memory and I/O bus slave attached directly downstream of the 8-bit CPU core's `address` / `data_out` / `write` outputs. It also sources the CPU's `data_in`. It decodes the 8-bit address space into:
- internal RAM;
- a 4-register I/O window holding a TX FIFO, an RX FIFO, a status register and a free-running timer;
- a pass-through port to an external program ROM in the upper half (0x80–0xFF, where the CPU starts execution).

---
 rtl/cpu_bus_io_if.sv | 47 ++++
 rtl/cpu_bus_io.sv | 195 +++++++++++++++++++
 tb/tb_cpu_bus_io.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_io_if.sv
// CPU-side bus, external ROM port and TX/RX byte streams of the bus slave.
// The slave modport is the bus slave's view. The master modport is the view of
// whatever drives the CPU bus and the external ports.
interface cpu_bus_io_if;
    logic [7:0] address;
    logic [7:0] data_out;
    logic       write;
    logic [7:0] data_in;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport slave (
        input  address,
        input  data_out,
        input  write,
        output data_in,
        output rom_addr,
        input  rom_data,
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

    modport master (
        output address,
        output data_out,
        output write,
        input  data_in,
        input  rom_addr,
        output rom_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        input  rx_ready
    );
endinterface

// File: rtl/cpu_bus_io.sv
// Memory and I/O bus slave for the 8-bit CPU.
// It holds 128 bytes of RAM and an I/O window at 0x0C-0x0F with a TX FIFO,
// status, an RX FIFO and a timer. It also passes reads of 0x80-0xFF through
// to the external ROM. All reads are combinational from the address.
module cpu_bus_io #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMER_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    cpu_bus_io_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0]    ADDR_TX     = 8'h0C;
    localparam logic [7:0]    ADDR_STATUS = 8'h0D;
    localparam logic [7:0]    ADDR_RX     = 8'h0E;
    localparam logic [7:0]    ADDR_TIMER  = 8'h0F;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    PRESC_LAST  = 8'(TIMER_DIV - 1);

    // Storage. None of it is reset. FIFO entries are only meaningful between
    // the FIFO pointers.
    logic [7:0] ram    [0:127];
    logic [7:0] tx_mem [0:FIFO_DEPTH-1];
    logic [7:0] rx_mem [0:FIFO_DEPTH-1];

    logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [CW-1:0] tx_count_reg,  rx_count_reg;
    logic          tx_ovf_reg;
    logic [7:0]    timer_reg;
    logic [7:0]    presc_reg;
    logic [7:0]    addr_q;

    logic sel_tx, sel_status, sel_rx, sel_timer, sel_ram;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_pop, tx_push_req, tx_push, tx_ovf_set, tx_ovf_clr;
    logic rx_push, rx_pop;
    logic timer_load, timer_tick;
    logic ram_write;
    logic [7:0] status;
    logic [7:0] rx_head;
    logic [7:0] read_data;

    assign sel_tx     = (bus.address == ADDR_TX);
    assign sel_status = (bus.address == ADDR_STATUS);
    assign sel_rx     = (bus.address == ADDR_RX);
    assign sel_timer  = (bus.address == ADDR_TIMER);
    // RAM covers the lower half except the four I/O registers.
    assign sel_ram    = !bus.address[7] && (bus.address[7:2] != 6'b000011);

    assign tx_empty = (tx_count_reg == '0);
    assign tx_full  = (tx_count_reg == FULL_COUNT);
    assign rx_empty = (rx_count_reg == '0);
    assign rx_full  = (rx_count_reg == FULL_COUNT);

    // If a pop frees a slot in the same cycle, a push to a full TX FIFO is still taken.
    assign tx_pop      = !tx_empty && bus.tx_ready;
    assign tx_push_req = bus.write && sel_tx;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_ovf_set  = tx_push_req && tx_full && !tx_pop;
    assign tx_ovf_clr  = bus.write && sel_status && bus.data_out[4];

    // An RX read pops only on the first cycle of an access to RX_DATA.
    // Holding the address there does not pop again.
    assign rx_push = bus.rx_valid && !rx_full;
    assign rx_pop  = sel_rx && (addr_q != ADDR_RX) && !rx_empty;

    assign timer_load = bus.write && sel_timer;
    assign timer_tick = (presc_reg == PRESC_LAST);

    assign ram_write = bus.write && sel_ram;

    assign status  = {3'b000, tx_ovf_reg, tx_full, tx_empty, rx_full, !rx_empty};
    assign rx_head = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];

    // Read mux: ROM in the upper half, I/O registers at 0x0C-0x0F, RAM elsewhere.
    always_comb begin
        read_data = ram[bus.address[6:0]];
        if (bus.address[7]) begin
            read_data = bus.rom_data;
        end else begin
            case (bus.address)
                ADDR_TX:     read_data = 8'(tx_count_reg);
                ADDR_STATUS: read_data = status;
                ADDR_RX:     read_data = rx_head;
                ADDR_TIMER:  read_data = timer_reg;
                default:     read_data = ram[bus.address[6:0]];
            endcase
        end
    end

    assign bus.data_in  = read_data;
    assign bus.rom_addr = bus.address[6:0];
    assign bus.tx_data  = tx_mem[tx_rd_ptr_reg];
    assign bus.tx_valid = !tx_empty;
    assign bus.rx_ready = !rx_full;

    // RAM write port
    always_ff @(posedge clk) begin
        if (ram_write) begin
            ram[bus.address[6:0]] <= bus.data_out;
        end
    end

    // TX FIFO storage write
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_reg] <= bus.data_out;
        end
    end

    // RX FIFO storage write
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_reg] <= bus.rx_data;
        end
    end

    // TX FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
            tx_ovf_reg    <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count_reg <= tx_count_reg + 1'b1;
                2'b01:   tx_count_reg <= tx_count_reg - 1'b1;
                default: tx_count_reg <= tx_count_reg;
            endcase
            // If a clear and a new overflow happen together, the flag ends up set.
            if (tx_ovf_set) begin
                tx_ovf_reg <= 1'b1;
            end else if (tx_ovf_clr) begin
                tx_ovf_reg <= 1'b0;
            end
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            end
            if (rx_pop) begin
                rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
                2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
                default: rx_count_reg <= rx_count_reg;
            endcase
        end
    end

    // Free-running timer with prescaler; a CPU write overrides a coincident tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_reg <= 8'h00;
            presc_reg <= 8'h00;
        end else if (timer_load) begin
            timer_reg <= bus.data_out;
            presc_reg <= 8'h00;
        end else if (timer_tick) begin
            timer_reg <= timer_reg + 8'h01;
            presc_reg <= 8'h00;
        end else begin
            presc_reg <= presc_reg + 8'h01;
        end
    end

    // Previous-cycle address, used to detect the first cycle of an RX_DATA access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= 8'h00;
        end else begin
            addr_q <= bus.address;
        end
    end
endmodule

// File: tb/tb_cpu_bus_io.sv
// Testbench for cpu_bus_io.
// The reference model uses queues for the FIFOs and a byte array for RAM.
// It computes the timer value as the load value plus elapsed cycles divided by the divider.
`timescale 1ns/1ps
module tb_cpu_bus_io;
    localparam int DEPTH = 4;
    localparam int DIV   = 3;

    logic clk = 1'b0;
    logic reset;

    cpu_bus_io_if bus_if();

    cpu_bus_io #(.FIFO_DEPTH(DEPTH), .TIMER_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] ram_m [128];
    bit         ram_known [128];
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    bit         ovf_m;
    int         t_load;
    int         t_cycles;
    logic [7:0] last_addr;

    function automatic logic [7:0] timer_m();
        return 8'((t_load + t_cycles / DIV) % 256);
    endfunction

    function automatic logic [7:0] status_m();
        return {3'b000, ovf_m, txq.size() == DEPTH, txq.size() == 0,
                rxq.size() == DEPTH, rxq.size() != 0};
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        if (a >= 8'h80) return bus_if.rom_data;
        case (a)
            8'h0C:   return 8'(txq.size());
            8'h0D:   return status_m();
            8'h0E:   return (rxq.size() != 0) ? rxq[0] : 8'h00;
            8'h0F:   return timer_m();
            default: return ram_m[a[6:0]];
        endcase
    endfunction

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        ovf_m     = 1'b0;
        t_load    = 0;
        t_cycles  = 0;
        last_addr = 8'h00;
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic [7:0] a       = bus_if.address;
        logic [7:0] d       = bus_if.data_out;
        bit         wr      = bus_if.write;
        bit         tx_pop  = (txq.size() != 0) && bus_if.tx_ready;
        bit         rx_push = bus_if.rx_valid && (rxq.size() < DEPTH);
        bit         rx_pop  = (a == 8'h0E) && (last_addr != 8'h0E) && (rxq.size() != 0);
        bit         ovf_new = 1'b0;
        if (tx_pop) void'(txq.pop_front());
        if (wr && a == 8'h0C) begin
            if (txq.size() < DEPTH) txq.push_back(d);
            else ovf_new = 1'b1;
        end
        if (rx_pop) void'(rxq.pop_front());
        if (rx_push) rxq.push_back(bus_if.rx_data);
        if (wr && a == 8'h0D && d[4]) ovf_m = 1'b0;
        if (ovf_new) ovf_m = 1'b1;
        if (wr && a == 8'h0F) begin
            t_load   = int'(d);
            t_cycles = 0;
        end else begin
            t_cycles++;
        end
        if (wr && a < 8'h80 && (a < 8'h0C || a > 8'h0F)) begin
            ram_m[a[6:0]]     = d;
            ram_known[a[6:0]] = 1'b1;
        end
        last_addr = a;
    endtask

    // Commit one clock edge to the model and the DUT, then return at the next falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] a, input logic w, input logic [7:0] d);
        bus_if.address  = a;
        bus_if.write    = w;
        bus_if.data_out = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(8'h0D, 1'b0, 8'h00);
        bus_if.tx_ready = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rom_data = 8'h00;
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h04) begin
            miscompares++;
            $display("FAIL reset_status: got %02h expected 04", bus_if.data_in);
        end
        vectors++;
        if (bus_if.tx_valid !== 1'b0 || bus_if.rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_flags: tx_valid=%b rx_ready=%b expected 0/1", bus_if.tx_valid, bus_if.rx_ready);
        end
        drive(8'h0F, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_timer: got %02h expected 00", bus_if.data_in);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        $display("[reset] released");
    endtask

    task automatic test_ram();
        drive(8'h03, 1'b1, 8'hA5); tick();
        drive(8'h05, 1'b1, 8'h5A); tick();
        drive(8'h85, 1'b1, 8'h99); tick();
        drive(8'h03, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'hA5) begin
            miscompares++;
            $display("FAIL ram_read: got %02h expected a5", bus_if.data_in);
        end
        drive(8'h05, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h5A) begin
            miscompares++;
            $display("FAIL rom_write_ignored: ram[05] got %02h expected 5a", bus_if.data_in);
        end
        bus_if.rom_data = 8'h3C;
        drive(8'h85, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h3C || bus_if.rom_addr !== 7'h05) begin
            miscompares++;
            $display("FAIL rom_read: data_in=%02h rom_addr=%02h expected 3c/05", bus_if.data_in, bus_if.rom_addr);
        end
        $display("[ram] write/read 03, rom 85 done");
        tick();
    endtask

    task automatic test_tx();
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(8'h0C, 1'b1, bytes[i]);
            tick();
        end
        drive(8'h0D, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h18) begin
            miscompares++;
            $display("FAIL tx_status_full_ovf: got %02h expected 18", bus_if.data_in);
        end
        drive(8'h0C, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h04) begin
            miscompares++;
            $display("FAIL tx_count: got %02h expected 04", bus_if.data_in);
        end
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== bytes[i]) begin
                miscompares++;
                $display("FAIL tx_drain_%0d: valid=%b data=%02h expected 1/%02h", i, bus_if.tx_valid, bus_if.tx_data, bytes[i]);
            end
            $display("[tx] popped %02h", bus_if.tx_data);
            tick();
        end
        #1;
        vectors++;
        if (bus_if.tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_empty_after_drain: tx_valid=%b expected 0", bus_if.tx_valid);
        end
        bus_if.tx_ready = 1'b0;
        drive(8'h0D, 1'b1, 8'h10); tick();
        drive(8'h0D, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h04) begin
            miscompares++;
            $display("FAIL tx_ovf_clear: status %02h expected 04", bus_if.data_in);
        end
    endtask

    task automatic test_tx_boundary();
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(8'h0C, 1'b1, 8'(8'hA0 + i));
            tick();
        end
        // Full FIFO with a pop in the same cycle: the push is accepted, no overflow
        bus_if.tx_ready = 1'b1;
        drive(8'h0C, 1'b1, 8'hB4); tick();
        bus_if.tx_ready = 1'b0;
        drive(8'h0D, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h08 || bus_if.tx_data !== 8'hA1) begin
            miscompares++;
            $display("FAIL tx_full_push_pop: status=%02h head=%02h expected 08/a1", bus_if.data_in, bus_if.tx_data);
        end
        drive(8'h0C, 1'b1, 8'hC5); tick();
        drive(8'h0D, 1'b1, 8'hEF); tick();
        drive(8'h0D, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h18) begin
            miscompares++;
            $display("FAIL tx_ovf_sticky: status=%02h expected 18", bus_if.data_in);
        end
        drive(8'h0D, 1'b1, 8'h10); tick();
        drive(8'h0D, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h08) begin
            miscompares++;
            $display("FAIL tx_ovf_clear_full: status=%02h expected 08", bus_if.data_in);
        end
        drive(8'h00, 1'b0, 8'h00);
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        bus_if.tx_ready = 1'b0;
        #1;
        vectors++;
        if (bus_if.tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_boundary_drain: tx_valid=%b expected 0", bus_if.tx_valid);
        end
        $display("[tx_boundary] full push+pop, ovf sticky/clear done");
    endtask

    task automatic test_rx();
        drive(8'h00, 1'b0, 8'h00);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h7E; tick();
        bus_if.rx_data  = 8'h81; tick();
        bus_if.rx_valid = 1'b0;
        drive(8'h0D, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h05) begin
            miscompares++;
            $display("FAIL rx_status_nonempty: got %02h expected 05", bus_if.data_in);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] e = (k == 0) ? 8'h7E : 8'h81;
            drive(8'h0E, 1'b0, 8'h00);
            #1;
            vectors++;
            if (bus_if.data_in !== e) begin
                miscompares++;
                $display("FAIL rx_hold_%0d: got %02h expected %02h", k, bus_if.data_in, e);
            end
            $display("[rx] hold cycle %0d read %02h", k, bus_if.data_in);
            tick();
        end
        drive(8'h0D, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h05) begin
            miscompares++;
            $display("FAIL rx_single_pop: status %02h expected 05", bus_if.data_in);
        end
        tick();
        drive(8'h0E, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h81) begin
            miscompares++;
            $display("FAIL rx_second_read: got %02h expected 81", bus_if.data_in);
        end
        tick();
        drive(8'h0D, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h04) begin
            miscompares++;
            $display("FAIL rx_drained: status %02h expected 04", bus_if.data_in);
        end
        tick();
        drive(8'h0E, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h00) begin
            miscompares++;
            $display("FAIL rx_empty_read: got %02h expected 00", bus_if.data_in);
        end
        tick();
    endtask

    task automatic test_timer();
        drive(8'h0F, 1'b1, 8'hFE); tick();
        drive(8'h0F, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'hFE) begin
            miscompares++;
            $display("FAIL timer_load: got %02h expected fe", bus_if.data_in);
        end
        for (int i = 0; i < 3; i++) tick();
        #1;
        vectors++;
        if (bus_if.data_in !== 8'hFF) begin
            miscompares++;
            $display("FAIL timer_plus1: got %02h expected ff", bus_if.data_in);
        end
        for (int i = 0; i < 3; i++) tick();
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h00) begin
            miscompares++;
            $display("FAIL timer_wrap: got %02h expected 00", bus_if.data_in);
        end
        $display("[timer] load fe -> ff -> 00 done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            logic [7:0] e;
            bit         w;
            bit         countable;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = bus_if.address;
            w = !bus_if.write && ($urandom_range(0, 2) == 0);
            bus_if.tx_ready = ($urandom_range(0, 3) == 0);
            bus_if.rx_valid = ($urandom_range(0, 1) == 1);
            bus_if.rx_data  = 8'($urandom);
            bus_if.rom_data = 8'($urandom);
            drive(a, w, 8'($urandom));
            #1;
            e = exp_read(a);
            countable = !(a < 8'h80 && (a < 8'h0C || a > 8'h0F) && !ram_known[a[6:0]]);
            if (countable) begin
                vectors++;
                if (bus_if.data_in !== e) begin
                    miscompares++;
                    $display("FAIL rand_read_%0d: addr=%02h got %02h expected %02h", i, a, bus_if.data_in, e);
                end
            end
            vectors++;
            if (bus_if.tx_valid !== (txq.size() != 0) || bus_if.rx_ready !== (rxq.size() < DEPTH)
                || bus_if.rom_addr !== a[6:0]) begin
                miscompares++;
                $display("FAIL rand_flags_%0d: tx_valid=%b rx_ready=%b rom_addr=%02h expected %b/%b/%02h", i,
                         bus_if.tx_valid, bus_if.rx_ready, bus_if.rom_addr, txq.size() != 0, rxq.size() < DEPTH, a[6:0]);
            end
            if (txq.size() != 0) begin
                vectors++;
                if (bus_if.tx_data !== txq[0]) begin
                    miscompares++;
                    $display("FAIL rand_tx_head_%0d: got %02h expected %02h", i, bus_if.tx_data, txq[0]);
                end
            end
            $display("[rand %0d] addr=%02h wr=%0b dout=%02h din=%02h txn=%0d rxn=%0d", i, a, w,
                     bus_if.data_out, bus_if.data_in, txq.size(), rxq.size());
            tick();
        end
        bus_if.write    = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(8'h0C, 1'b1, 8'h21); tick();
        drive(8'h0C, 1'b1, 8'h22); tick();
        drive(8'h00, 1'b0, 8'h00);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h31; tick();
        bus_if.rx_data  = 8'h32; tick();
        bus_if.rx_valid = 1'b0;
        drive(8'h0F, 1'b1, 8'h77); tick();
        drive(8'h0F, 1'b0, 8'h00);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (bus_if.tx_valid !== 1'b0 || bus_if.rx_ready !== 1'b1 || bus_if.data_in !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: tx_valid=%b rx_ready=%b timer=%02h expected 0/1/00",
                     bus_if.tx_valid, bus_if.rx_ready, bus_if.data_in);
        end
        drive(8'h0D, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h04) begin
            miscompares++;
            $display("FAIL reset_async_status: got %02h expected 04", bus_if.data_in);
        end
        drive(8'h03, 1'b0, 8'h00);
        #1;
        if (ram_known[3]) begin
            vectors++;
            if (bus_if.data_in !== ram_m[3]) begin
                miscompares++;
                $display("FAIL reset_ram_retained: got %02h expected %02h", bus_if.data_in, ram_m[3]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drive(8'h0D, 1'b0, 8'h00);
        #1;
        vectors++;
        if (bus_if.data_in !== 8'h04) begin
            miscompares++;
            $display("FAIL reset_release_status: got %02h expected 04", bus_if.data_in);
        end
        $display("[reset_mid] asynchronous reset with both FIFOs loaded done");
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) ram_known[i] = 1'b0;
        model_reset();
        test_reset();
        test_ram();
        test_tx();
        test_rx();
        test_timer();
        test_tx_boundary();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
